fcvt_issue_ctrl: RTL and testbench
==================================

FCVT_ISSUE_CTRL -- requirements
Module: fcvt_issue_ctrl

Interface
REQ-001: The module SHALL have parameter TAG_W, default 6, giving the ROB tag width carried with each conversion.
REQ-002: CLK  input  1  the only clock; all state updates on its rising edge.
REQ-003: RST_N  input  1  asynchronous, active-low reset.
REQ-004: REQ0_VALID, REQ1_VALID  input  1 each  issue-lane conversion request valid.
REQ-005: REQ0_READY, REQ1_READY  output  1 each  lane request accepted this cycle.
REQ-006: REQn_OPND  input  64  FP source operand (SP in bits [31:0]); REQn_ISDBL, REQn_UNS, REQn_ISWORD  input  1 each  conversion type.
REQ-007: REQn_RM  input  3  instruction rounding mode; REQn_TAG  input  TAG_W  ROB tag.
REQ-008: FRM  input  3  CSR dynamic rounding mode.
REQ-009: FLUSH  input  1  pipeline kill.
REQ-010: RES_VALID  output  1; RES_READY  input  1; RES_DATA  output  64; RES_FFLAGS  output  5 {NV,DZ,OF,UF,NX}; RES_TAG  output  TAG_W.
REQ-011: BUSY  output  1  high while any stage holds a valid op.

Function
REQ-012: The block SHALL contain two pipeline registers: S1 (selected request) and S2 (converted result), each with a valid bit.
REQ-013: S1 operands SHALL drive one instance of the FP-to-integer converter combinationally; its 64-bit output and invalid indication SHALL be captured into S2.
REQ-014: S2 advance condition adv2 = ~S2_V | RES_READY; S1 advance condition adv1 = ~S1_V | adv2.
REQ-015: A lane SHALL be granted only when adv1=1 and FLUSH=0; REQn_READY = grant_n; at most one READY high per cycle.
REQ-016: Arbitration SHALL be round-robin with a 1-bit pointer RR: both valid -> grant lane RR; only one valid -> grant it; on any grant RR becomes the non-granted lane index; no grant -> RR unchanged.
REQ-017: Rounding mode resolution at capture: RM=3'b111 SHALL be replaced by FRM; all other codes SHALL pass unmodified.
REQ-018: On grant, S1 SHALL load operand, type bits, resolved RM and tag, and set S1_V=1; on adv1 without grant, S1_V SHALL clear.
REQ-019: On adv2, S2 SHALL load converter output, NV=converter invalid, tag, and S2_V=S1_V; other fflags bits SHALL be 0.
REQ-020: When S2_V=1 and RES_READY=0, S2 and RES_* SHALL hold stable; S1 SHALL hold if valid.
REQ-021: Latency: accepted in cycle N, RES_VALID=1 in cycle N+2 with no backpressure; sustained throughput one conversion per cycle.
REQ-022: FLUSH=1 SHALL clear S1_V and S2_V at the next edge, suppress grants that cycle, and leave RR unchanged; a result handshaking in the flush cycle is still delivered.
REQ-023: RES_VALID = S2_V; RES_DATA/FFLAGS/TAG are S2 registers; BUSY = S1_V | S2_V.
REQ-024: Request fields SHALL be sampled only on grant; changes on a non-granted lane have no effect.

Reset
REQ-025: While RST_N=0: S1_V=0, S2_V=0, RR=0, RES_VALID=0, RES_DATA=0, RES_FFLAGS=0, RES_TAG=0, BUSY=0, REQn_READY=0.
REQ-026: Reset assertion mid-operation SHALL discard all in-flight ops immediately; first grant possible in the first cycle after deassertion.

Verification
REQ-027: Lane0 OPND=0x3FF8000000000000, ISDBL=1, ISWORD=1, UNS=0, RM=000, TAG=5, RES_READY=1 -> two cycles later RES_DATA=0x0000000000000002, FFLAGS=0, TAG=5.
REQ-028: Lane1 OPND=0xC004000000000000 fcvt.l.d RM=111, FRM=001 -> RES_DATA=0xFFFFFFFFFFFFFFFE; with FRM=000 -> same; OPND=0x3FF8000000000000 RM=111 FRM=001 -> 1.
REQ-029: OPND=0x7FF8000000000000 fcvt.w.d signed -> RES_DATA=0x000000007FFFFFFF, FFLAGS=5'b10000.
REQ-030: Both lanes valid every cycle after reset, tags 0..7 alternating -> grants lane0, lane1, lane0, ...; results in grant order, one per cycle.
REQ-031: RES_READY=0 for 3 cycles with 3 requests offered -> RES_* stable, S1 holds, third request READY=0 until RES_READY=1; no loss or duplication.
REQ-032: FLUSH pulse with S1_V=S2_V=1 -> next cycle RES_VALID=0, BUSY=0, no READY during flush; RST_N low mid-stream -> all outputs zero immediately.

Source files
------------

// File: rtl/fcvt_issue_ctrl.sv
// Two-lane FP-to-integer conversion issue controller: round-robin lane select,
// a capture stage (S1) feeding one combinational converter, and a result stage (S2).

module fcvt_f2i (
  input  logic [63:0] opnd,
  input  logic        is_dbl,
  input  logic        is_uns,
  input  logic        is_word,
  input  logic [2:0]  rm,
  output logic [63:0] result,
  output logic        invalid
);

  logic         sign;
  logic [12:0]  exp_unb;
  logic [52:0]  mant;
  logic         is_nan;
  logic         big;
  logic [115:0] fixed;
  logic [63:0]  int_part;
  logic         rnd;
  logic         sticky;
  logic         inc;
  logic [64:0]  mag;
  logic [64:0]  pos_lim;
  logic [64:0]  neg_lim;
  logic [63:0]  sat;
  logic [63:0]  conv;
  logic [63:0]  raw;

  always_comb begin
    if (is_dbl) begin
      sign    = opnd[63];
      exp_unb = {2'b00, opnd[62:52]} - 13'd1023;
      mant    = {|opnd[62:52], opnd[51:0]};
      is_nan  = (&opnd[62:52]) & (|opnd[51:0]);
    end else begin
      sign    = opnd[31];
      exp_unb = {5'b00000, opnd[30:23]} - 13'd127;
      mant    = {|opnd[30:23], opnd[22:0], 29'b0};
      is_nan  = (&opnd[30:23]) & (|opnd[22:0]);
    end

    // exp_unb is two's complement; bit 12 set means magnitude below 1.0
    big   = ~exp_unb[12] & (|exp_unb[11:6]);
    fixed = {63'b0, mant} << exp_unb[5:0];

    int_part = 64'd0;
    rnd      = 1'b0;
    sticky   = 1'b0;
    if (!exp_unb[12]) begin
      int_part = fixed[115:52];
      rnd      = fixed[51];
      sticky   = |fixed[50:0];
    end else if (exp_unb == 13'h1FFF) begin
      rnd    = mant[52];
      sticky = |mant[51:0];
    end else begin
      sticky = |mant;
    end

    case (rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign & (rnd | sticky);
      3'b011:  inc = ~sign & (rnd | sticky);
      3'b100:  inc = rnd;
      default: inc = rnd & (sticky | int_part[0]);
    endcase
    mag = {1'b0, int_part} + {64'd0, inc};

    case ({is_word, is_uns})
      2'b00: begin
        pos_lim = 65'h0_7FFF_FFFF_FFFF_FFFF;
        neg_lim = 65'h0_8000_0000_0000_0000;
        sat     = (is_nan | ~sign) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
      end
      2'b01: begin
        pos_lim = 65'h0_FFFF_FFFF_FFFF_FFFF;
        neg_lim = 65'd0;
        sat     = (is_nan | ~sign) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
      end
      2'b10: begin
        pos_lim = 65'h0_0000_0000_7FFF_FFFF;
        neg_lim = 65'h0_0000_0000_8000_0000;
        sat     = (is_nan | ~sign) ? 64'h0000_0000_7FFF_FFFF : 64'h0000_0000_8000_0000;
      end
      default: begin
        pos_lim = 65'h0_0000_0000_FFFF_FFFF;
        neg_lim = 65'd0;
        sat     = (is_nan | ~sign) ? 64'h0000_0000_FFFF_FFFF : 64'd0;
      end
    endcase

    invalid = is_nan | big | (sign ? (mag > neg_lim) : (mag > pos_lim));
    conv    = sign ? (~mag[63:0] + 64'd1) : mag[63:0];
    raw     = invalid ? sat : conv;
    // word results are sign-extended to 64 bits, including the unsigned forms
    result  = is_word ? {{32{raw[31]}}, raw[31:0]} : raw;
  end

endmodule

module fcvt_issue_ctrl #(
  parameter int TAG_W = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [63:0]      REQ0_OPND,
  input  logic             REQ0_ISDBL,
  input  logic             REQ0_UNS,
  input  logic             REQ0_ISWORD,
  input  logic [2:0]       REQ0_RM,
  input  logic [TAG_W-1:0] REQ0_TAG,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [63:0]      REQ1_OPND,
  input  logic             REQ1_ISDBL,
  input  logic             REQ1_UNS,
  input  logic             REQ1_ISWORD,
  input  logic [2:0]       REQ1_RM,
  input  logic [TAG_W-1:0] REQ1_TAG,
  input  logic [2:0]       FRM,
  input  logic             FLUSH,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [63:0]      RES_DATA,
  output logic [4:0]       RES_FFLAGS,
  output logic [TAG_W-1:0] RES_TAG,
  output logic             BUSY
);

  logic             s1_v_q, s1_v_d;
  logic [63:0]      s1_opnd_q, s1_opnd_d;
  logic             s1_dbl_q, s1_dbl_d;
  logic             s1_uns_q, s1_uns_d;
  logic             s1_word_q, s1_word_d;
  logic [2:0]       s1_rm_q, s1_rm_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_v_q, s2_v_d;
  logic [63:0]      s2_data_q, s2_data_d;
  logic             s2_nv_q, s2_nv_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             rr_q, rr_d;

  logic        adv1, adv2, can_grant, grant0, grant1;
  logic [2:0]  sel_rm;
  logic [63:0] cvt_result;
  logic        cvt_invalid;

  fcvt_f2i u_f2i (
    .opnd    (s1_opnd_q),
    .is_dbl  (s1_dbl_q),
    .is_uns  (s1_uns_q),
    .is_word (s1_word_q),
    .rm      (s1_rm_q),
    .result  (cvt_result),
    .invalid (cvt_invalid)
  );

  // READY is gated by RST_N so no lane is acknowledged while reset is held
  always_comb begin
    adv2      = ~s2_v_q | RES_READY;
    adv1      = ~s1_v_q | adv2;
    can_grant = adv1 & ~FLUSH & RST_N;
    grant0    = can_grant & REQ0_VALID & (~REQ1_VALID | ~rr_q);
    grant1    = can_grant & REQ1_VALID & (~REQ0_VALID | rr_q);
    sel_rm    = grant1 ? REQ1_RM : REQ0_RM;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_opnd_d = s1_opnd_q;
    s1_dbl_d  = s1_dbl_q;
    s1_uns_d  = s1_uns_q;
    s1_word_d = s1_word_q;
    s1_rm_d   = s1_rm_q;
    s1_tag_d  = s1_tag_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_nv_d   = s2_nv_q;
    s2_tag_d  = s2_tag_q;
    rr_d      = rr_q;

    if (grant0 | grant1) begin
      s1_v_d    = 1'b1;
      s1_opnd_d = grant1 ? REQ1_OPND   : REQ0_OPND;
      s1_dbl_d  = grant1 ? REQ1_ISDBL  : REQ0_ISDBL;
      s1_uns_d  = grant1 ? REQ1_UNS    : REQ0_UNS;
      s1_word_d = grant1 ? REQ1_ISWORD : REQ0_ISWORD;
      s1_tag_d  = grant1 ? REQ1_TAG    : REQ0_TAG;
      s1_rm_d   = (sel_rm == 3'b111) ? FRM : sel_rm;
      rr_d      = grant0;
    end else if (adv1) begin
      s1_v_d = 1'b0;
    end

    if (adv2) begin
      s2_v_d    = s1_v_q;
      s2_data_d = cvt_result;
      s2_nv_d   = cvt_invalid;
      s2_tag_d  = s1_tag_q;
    end

    if (FLUSH) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v_q    <= 1'b0;
      s1_opnd_q <= 64'd0;
      s1_dbl_q  <= 1'b0;
      s1_uns_q  <= 1'b0;
      s1_word_q <= 1'b0;
      s1_rm_q   <= 3'd0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= 64'd0;
      s2_nv_q   <= 1'b0;
      s2_tag_q  <= '0;
      rr_q      <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_opnd_q <= s1_opnd_d;
      s1_dbl_q  <= s1_dbl_d;
      s1_uns_q  <= s1_uns_d;
      s1_word_q <= s1_word_d;
      s1_rm_q   <= s1_rm_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_nv_q   <= s2_nv_d;
      s2_tag_q  <= s2_tag_d;
      rr_q      <= rr_d;
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign RES_VALID  = s2_v_q;
  assign RES_DATA   = s2_data_q;
  assign RES_FFLAGS = {s2_nv_q, 4'b0000};
  assign RES_TAG    = s2_tag_q;
  assign BUSY       = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_fcvt_issue_ctrl.sv
// Directed bench for fcvt_issue_ctrl: conversion vectors, round-robin streaming,
// backpressure, flush and mid-stream reset.

module tb_fcvt_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0_VALID, REQ0_READY, REQ0_ISDBL, REQ0_UNS, REQ0_ISWORD;
  logic [63:0] REQ0_OPND;
  logic [2:0]  REQ0_RM;
  logic [5:0]  REQ0_TAG;
  logic        REQ1_VALID, REQ1_READY, REQ1_ISDBL, REQ1_UNS, REQ1_ISWORD;
  logic [63:0] REQ1_OPND;
  logic [2:0]  REQ1_RM;
  logic [5:0]  REQ1_TAG;
  logic [2:0]  FRM;
  logic        FLUSH;
  logic        RES_VALID, RES_READY, BUSY;
  logic [63:0] RES_DATA;
  logic [4:0]  RES_FFLAGS;
  logic [5:0]  RES_TAG;

  int checks = 0;
  int errors = 0;

  fcvt_issue_ctrl #(.TAG_W(6)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OPND(REQ0_OPND),
    .REQ0_ISDBL(REQ0_ISDBL), .REQ0_UNS(REQ0_UNS), .REQ0_ISWORD(REQ0_ISWORD),
    .REQ0_RM(REQ0_RM), .REQ0_TAG(REQ0_TAG),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OPND(REQ1_OPND),
    .REQ1_ISDBL(REQ1_ISDBL), .REQ1_UNS(REQ1_UNS), .REQ1_ISWORD(REQ1_ISWORD),
    .REQ1_RM(REQ1_RM), .REQ1_TAG(REQ1_TAG),
    .FRM(FRM), .FLUSH(FLUSH),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_FFLAGS(RES_FFLAGS), .RES_TAG(RES_TAG), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive_lane(input int lane, input logic v, input logic [63:0] op,
                            input logic dbl, input logic uns, input logic word,
                            input logic [2:0] rm, input logic [5:0] tag);
    if (lane == 0) begin
      REQ0_VALID = v; REQ0_OPND = op; REQ0_ISDBL = dbl; REQ0_UNS = uns;
      REQ0_ISWORD = word; REQ0_RM = rm; REQ0_TAG = tag;
    end else begin
      REQ1_VALID = v; REQ1_OPND = op; REQ1_ISDBL = dbl; REQ1_UNS = uns;
      REQ1_ISWORD = word; REQ1_RM = rm; REQ1_TAG = tag;
    end
  endtask

  // One isolated conversion: request in cycle N, result checked in cycle N+2
  task automatic run_convert(input string name, input int lane, input logic [63:0] op,
                             input logic dbl, input logic uns, input logic word,
                             input logic [2:0] rm, input logic [2:0] frm, input logic [5:0] tag,
                             input logic [63:0] exp_data, input logic [4:0] exp_flags);
    @(negedge CLK);
    FRM = frm;
    drive_lane(lane, 1'b1, op, dbl, uns, word, rm, tag);
    #1;
    check_output({name, "_ready"}, (lane == 0) ? REQ0_READY : REQ1_READY, 64'd1);
    @(negedge CLK);
    FRM = ~frm;
    drive_lane(lane, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1, 1'b0, 3'b011, 6'h3F);
    @(negedge CLK);
    #1;
    check_output({name, "_valid"}, RES_VALID, 64'd1);
    check_output({name, "_data"}, RES_DATA, exp_data);
    check_output({name, "_flags"}, RES_FFLAGS, exp_flags);
    check_output({name, "_tag"}, RES_TAG, tag);
  endtask

  logic [63:0] int_dbl [8];
  int idx0, idx1;
  logic [5:0] t0, t1;

  initial begin
    int_dbl[0] = 64'h0000_0000_0000_0000;
    int_dbl[1] = 64'h3FF0_0000_0000_0000;
    int_dbl[2] = 64'h4000_0000_0000_0000;
    int_dbl[3] = 64'h4008_0000_0000_0000;
    int_dbl[4] = 64'h4010_0000_0000_0000;
    int_dbl[5] = 64'h4014_0000_0000_0000;
    int_dbl[6] = 64'h4018_0000_0000_0000;
    int_dbl[7] = 64'h401C_0000_0000_0000;

    RST_N = 1'b0; FLUSH = 1'b0; RES_READY = 1'b1; FRM = 3'b000;
    drive_lane(0, 1'b1, int_dbl[1], 1'b1, 1'b0, 1'b0, 3'b000, 6'd1);
    drive_lane(1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0);

    // reset state with a request pending
    @(negedge CLK); #1;
    check_output("rst_ready0", REQ0_READY, 64'd0);
    check_output("rst_valid", RES_VALID, 64'd0);
    check_output("rst_busy", BUSY, 64'd0);
    check_output("rst_data", RES_DATA, 64'd0);
    check_output("rst_flags", RES_FFLAGS, 64'd0);
    check_output("rst_tag", RES_TAG, 64'd0);
    @(negedge CLK);
    drive_lane(0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0);
    RST_N = 1'b1;

    run_convert("w_d_rne_1p5", 0, 64'h3FF8_0000_0000_0000, 1, 0, 1, 3'b000, 3'b000, 6'd5,
                64'h0000_0000_0000_0002, 5'b00000);
    run_convert("l_d_dyn_rtz", 1, 64'hC004_0000_0000_0000, 1, 0, 0, 3'b111, 3'b001, 6'd6,
                64'hFFFF_FFFF_FFFF_FFFE, 5'b00000);
    run_convert("l_d_dyn_rne", 1, 64'hC004_0000_0000_0000, 1, 0, 0, 3'b111, 3'b000, 6'd7,
                64'hFFFF_FFFF_FFFF_FFFE, 5'b00000);
    run_convert("l_d_dyn_1p5", 1, 64'h3FF8_0000_0000_0000, 1, 0, 0, 3'b111, 3'b001, 6'd8,
                64'h0000_0000_0000_0001, 5'b00000);
    run_convert("w_d_nan", 0, 64'h7FF8_0000_0000_0000, 1, 0, 1, 3'b000, 3'b000, 6'd9,
                64'h0000_0000_7FFF_FFFF, 5'b10000);
    run_convert("w_s_rup_pi", 0, 64'h0000_0000_4049_0FDB, 0, 0, 1, 3'b011, 3'b000, 6'd10,
                64'h0000_0000_0000_0004, 5'b00000);
    run_convert("lu_d_neg", 1, 64'hBFF0_0000_0000_0000, 1, 1, 0, 3'b001, 3'b000, 6'd11,
                64'h0000_0000_0000_0000, 5'b10000);
    run_convert("l_d_2p63", 0, 64'h43E0_0000_0000_0000, 1, 0, 0, 3'b001, 3'b000, 6'd12,
                64'h7FFF_FFFF_FFFF_FFFF, 5'b10000);
    run_convert("l_d_m2p63", 0, 64'hC3E0_0000_0000_0000, 1, 0, 0, 3'b001, 3'b000, 6'd13,
                64'h8000_0000_0000_0000, 5'b00000);
    run_convert("wu_d_max", 1, 64'h41EF_FFFF_FFE0_0000, 1, 1, 1, 3'b001, 3'b000, 6'd14,
                64'hFFFF_FFFF_FFFF_FFFF, 5'b00000);
    run_convert("l_d_rmm_2p5", 0, 64'h4004_0000_0000_0000, 1, 0, 0, 3'b100, 3'b000, 6'd15,
                64'h0000_0000_0000_0003, 5'b00000);
    run_convert("l_d_rdn_m0p5", 1, 64'hBFE0_0000_0000_0000, 1, 0, 0, 3'b010, 3'b000, 6'd16,
                64'hFFFF_FFFF_FFFF_FFFF, 5'b00000);

    // backpressure: three requests while the result port stalls
    @(negedge CLK);
    RES_READY = 1'b0;
    drive_lane(0, 1'b1, int_dbl[1], 1, 0, 0, 3'b001, 6'd20);
    #1 check_output("bp_ready_a", REQ0_READY, 64'd1);
    @(negedge CLK);
    drive_lane(0, 1'b1, int_dbl[2], 1, 0, 0, 3'b001, 6'd21);
    #1 check_output("bp_ready_b", REQ0_READY, 64'd1);
    @(negedge CLK);
    drive_lane(0, 1'b1, int_dbl[3], 1, 0, 0, 3'b001, 6'd22);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge CLK);
      #1;
      check_output("bp_hold_ready", REQ0_READY, 64'd0);
      check_output("bp_hold_valid", RES_VALID, 64'd1);
      check_output("bp_hold_tag", RES_TAG, 64'd20);
      check_output("bp_hold_data", RES_DATA, 64'd1);
      check_output("bp_hold_busy", BUSY, 64'd1);
    end
    @(negedge CLK);
    RES_READY = 1'b1;
    #1;
    check_output("bp_release_ready", REQ0_READY, 64'd1);
    check_output("bp_out0_tag", RES_TAG, 64'd20);
    @(negedge CLK);
    drive_lane(0, 1'b0, 64'd0, 0, 0, 0, 3'b000, 6'd0);
    #1;
    check_output("bp_out1_tag", RES_TAG, 64'd21);
    check_output("bp_out1_data", RES_DATA, 64'd2);
    @(negedge CLK); #1;
    check_output("bp_out2_tag", RES_TAG, 64'd22);
    check_output("bp_out2_data", RES_DATA, 64'd3);
    @(negedge CLK); #1;
    check_output("bp_drained", RES_VALID, 64'd0);

    // flush with both stages full; lane1 grants leave the pointer at lane0
    @(negedge CLK);
    drive_lane(1, 1'b1, int_dbl[4], 1, 0, 0, 3'b001, 6'd30);
    @(negedge CLK);
    drive_lane(1, 1'b1, int_dbl[5], 1, 0, 0, 3'b001, 6'd31);
    @(negedge CLK);
    drive_lane(1, 1'b0, 64'd0, 0, 0, 0, 3'b000, 6'd0);
    drive_lane(0, 1'b1, int_dbl[6], 1, 0, 0, 3'b001, 6'd32);
    FLUSH = 1'b1;
    #1;
    check_output("fl_ready0", REQ0_READY, 64'd0);
    check_output("fl_ready1", REQ1_READY, 64'd0);
    check_output("fl_out_tag", RES_TAG, 64'd30);
    @(negedge CLK);
    FLUSH = 1'b0;
    drive_lane(0, 1'b0, 64'd0, 0, 0, 0, 3'b000, 6'd0);
    #1;
    check_output("fl_after_valid", RES_VALID, 64'd0);
    check_output("fl_after_busy", BUSY, 64'd0);
    @(negedge CLK);
    drive_lane(0, 1'b1, int_dbl[1], 1, 0, 0, 3'b001, 6'd33);
    drive_lane(1, 1'b1, int_dbl[2], 1, 0, 0, 3'b001, 6'd34);
    #1;
    check_output("fl_rr_ready0", REQ0_READY, 64'd1);
    check_output("fl_rr_ready1", REQ1_READY, 64'd0);
    @(negedge CLK);
    drive_lane(0, 1'b0, 64'd0, 0, 0, 0, 3'b000, 6'd0);
    drive_lane(1, 1'b0, 64'd0, 0, 0, 0, 3'b000, 6'd0);

    // reset asserted mid-stream between edges
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      drive_lane(0, 1'b1, int_dbl[k], 1, 0, 0, 3'b001, 6'(40 + k));
    end
    @(negedge CLK); #1;
    check_output("mr_pre_data", RES_DATA, 64'd2);
    #2 RST_N = 1'b0;
    #1;
    check_output("mr_valid", RES_VALID, 64'd0);
    check_output("mr_busy", BUSY, 64'd0);
    check_output("mr_ready0", REQ0_READY, 64'd0);
    check_output("mr_data", RES_DATA, 64'd0);
    check_output("mr_tag", RES_TAG, 64'd0);
    drive_lane(0, 1'b0, 64'd0, 0, 0, 0, 3'b000, 6'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // round-robin stream starting right after reset release
    idx0 = 0;
    idx1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      t0 = 6'(2 * idx0);
      t1 = 6'(2 * idx1 + 1);
      drive_lane(0, idx0 < 4, int_dbl[t0[2:0]], 1, 0, 0, 3'b001, t0);
      drive_lane(1, idx1 < 4, int_dbl[t1[2:0]], 1, 0, 0, 3'b001, t1);
      #1;
      check_output("rr_ready0", REQ0_READY, 64'((c < 8) && (c % 2 == 0)));
      check_output("rr_ready1", REQ1_READY, 64'((c < 8) && (c % 2 == 1)));
      if (c >= 2) begin
        check_output("rr_res_valid", RES_VALID, 64'd1);
        check_output("rr_res_tag", RES_TAG, 64'(c - 2));
        check_output("rr_res_data", RES_DATA, 64'(c - 2));
      end
      if (REQ0_READY) idx0++;
      if (REQ1_READY) idx1++;
    end
    @(negedge CLK); #1;
    check_output("rr_end_valid", RES_VALID, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
